// File: rtl/sparse_mac_pkg.sv
// Shared defaults and helpers for the sparse segmented MAC engine.
package sparse_mac_pkg;

  localparam int unsigned LANES_D = 4;
  localparam int unsigned DW_D    = 8;
  localparam int unsigned ACCW_D  = 28;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Sign-extend the low w bits of v to the full 64 bits.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = v;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= w) r[6'(i)] = v[6'(w - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sparse_seg_mac_if.sv
// Operand-in / result-out handshake bundle for sparse_seg_mac.
interface sparse_seg_mac_if
  import sparse_mac_pkg::*;
#(
  parameter int unsigned LANES = LANES_D,
  parameter int unsigned DW    = DW_D,
  parameter int unsigned ACCW  = ACCW_D
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*DW-1:0]    mat_in;
  logic [LANES*DW-1:0]    vec_in;
  logic [LANES-1:0]       in_keep;
  logic [LANES-1:0]       seg_end;
  logic                   in_clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_mask;
  logic [LANES*ACCW-1:0]  out_sum;

  modport master (
    output in_valid, mat_in, vec_in, in_keep, seg_end, in_clr, out_ready,
    input  in_ready, out_valid, out_mask, out_sum
  );

  modport slave (
    input  in_valid, mat_in, vec_in, in_keep, seg_end, in_clr, out_ready,
    output in_ready, out_valid, out_mask, out_sum
  );

endinterface

// File: rtl/seg_scan_level.sv
// One registered Hillis-Steele segmented-scan level at distance D.
module seg_scan_level
  import sparse_mac_pkg::*;
#(
  parameter int unsigned LANES = LANES_D,
  parameter int unsigned ACCW  = ACCW_D,
  parameter int unsigned D     = 1,
  parameter int unsigned SBW   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        valid_in,
  input  logic [LANES-1:0][ACCW-1:0]  val_in,
  input  logic [LANES-1:0]            flag_in,
  input  logic [SBW-1:0]              side_in,
  output logic                        valid_out,
  output logic [LANES-1:0][ACCW-1:0]  val_out,
  output logic [LANES-1:0]            flag_out,
  output logic [SBW-1:0]              side_out
);

  logic [LANES-1:0][ACCW-1:0] val_c;
  logic [LANES-1:0]           flag_c;

  // A set flag means a segment start lies inside the span this lane already covers.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    if (g >= D) begin : g_add
      assign val_c[g]  = flag_in[g] ? val_in[g] : val_in[g] + val_in[g-D];
      assign flag_c[g] = flag_in[g] | flag_in[g-D];
    end else begin : g_pass
      assign val_c[g]  = val_in[g];
      assign flag_c[g] = flag_in[g];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out <= 1'b0;
      val_out   <= '0;
      flag_out  <= '0;
      side_out  <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      val_out   <= val_c;
      flag_out  <= flag_c;
      side_out  <= side_in;
    end
  end

endmodule

// File: rtl/sparse_seg_mac.sv
// Pipelined sparse MAC: lane products, segmented scan, carried row accumulator.
module sparse_seg_mac
  import sparse_mac_pkg::*;
#(
  parameter int unsigned LANES = LANES_D,
  parameter int unsigned DW    = DW_D,
  parameter int unsigned ACCW  = ACCW_D
) (
  input logic              clk,
  input logic              rst,
  sparse_seg_mac_if.slave  bus
);

  localparam int unsigned LVLS = clog2(LANES);
  localparam int unsigned SBW  = LANES + 1;

  typedef logic [LANES-1:0][ACCW-1:0] lane_vec_t;

  logic             stall;
  lane_vec_t        prod_c;
  logic [LANES-1:0] start_c;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Lane 0 is left unflagged: it never adds a neighbour, and this way the final
  // flags read as "a segment ended somewhere below this lane".
  for (genvar g = 0; g < LANES; g++) begin : g_prod
    logic signed [2*DW-1:0] pr;
    assign pr        = $signed(bus.mat_in[g*DW +: DW]) * $signed(bus.vec_in[g*DW +: DW]);
    assign prod_c[g] = bus.in_keep[g] ? ACCW'(sext(64'(pr), 2*DW)) : '0;
    if (g == 0) begin : g_s0
      assign start_c[g] = 1'b0;
    end else begin : g_sn
      assign start_c[g] = bus.seg_end[g-1];
    end
  end

  logic             p_valid;
  lane_vec_t        p_val;
  logic [LANES-1:0] p_flag;
  logic [SBW-1:0]   p_side;

  // Product stage; sideband carries {in_clr, seg_end} down the pipe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_valid <= 1'b0;
      p_val   <= '0;
      p_flag  <= '0;
      p_side  <= '0;
    end else if (!stall) begin
      p_valid <= bus.in_valid;
      p_val   <= prod_c;
      p_flag  <= start_c;
      p_side  <= {bus.in_clr, bus.seg_end};
    end
  end

  logic             lv_valid [LVLS+1];
  lane_vec_t        lv_val   [LVLS+1];
  logic [LANES-1:0] lv_flag  [LVLS+1];
  logic [SBW-1:0]   lv_side  [LVLS+1];

  assign lv_valid[0] = p_valid;
  assign lv_val[0]   = p_val;
  assign lv_flag[0]  = p_flag;
  assign lv_side[0]  = p_side;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    seg_scan_level #(
      .LANES (LANES),
      .ACCW  (ACCW),
      .D     (32'd1 << k),
      .SBW   (SBW)
    ) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .en        (!stall),
      .valid_in  (lv_valid[k]),
      .val_in    (lv_val[k]),
      .flag_in   (lv_flag[k]),
      .side_in   (lv_side[k]),
      .valid_out (lv_valid[k+1]),
      .val_out   (lv_val[k+1]),
      .flag_out  (lv_flag[k+1]),
      .side_out  (lv_side[k+1])
    );
  end

  lane_vec_t        s;
  lane_vec_t        sum_c;
  logic [LANES-1:0] se;
  logic             clr;
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  a;
  logic [ACCW-1:0]  acc_next;

  assign s   = lv_val[LVLS];
  assign se  = lv_side[LVLS][LANES-1:0];
  assign clr = lv_side[LVLS][LANES];
  assign a   = clr ? '0 : acc;

  // Carry joins only lanes of the first segment (no seg_end below them).
  for (genvar g = 0; g < LANES; g++) begin : g_sum
    assign sum_c[g] = se[g] ? s[g] + (lv_flag[LVLS][g] ? '0 : a) : '0;
  end

  assign acc_next = se[LANES-1] ? '0 : s[LANES-1] + ((se == '0) ? a : '0);

  // Final stage: output register and accumulator, both frozen on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_mask  <= '0;
      bus.out_sum   <= '0;
      acc           <= '0;
    end else if (!stall) begin
      bus.out_valid <= lv_valid[LVLS];
      if (lv_valid[LVLS]) begin
        bus.out_mask <= se;
        bus.out_sum  <= sum_c;
        acc          <= acc_next;
      end
    end
  end

endmodule

// File: doc/sparse_seg_mac.md
# sparse_seg_mac

Parametrised, pipelined sparse matrix-vector multiply-accumulate engine: LANES signed products per beat feed a segmented reduction tree. Segment boundaries come from a per-lane end mask rather than a fixed pattern table, and partial row sums carry across beats in an accumulator. The block sits between the operand fetch logic (matrix/vector streams) and the result writeback buffer. Both sides use valid/ready handshakes, and the whole pipeline stalls globally on backpressure.

## Interface
- LANES, 4, products per beat; power of 2, ≥2
- DW, 8, operand width (signed)
- ACCW, 28, sum/accumulator width (signed); ≥ 2*DW+1
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- mat_in  in  LANES*DW  matrix operands; lane i = bits [i*DW +: DW]
- vec_in  in  LANES*DW  vector operands; same lane mapping
- in_keep  in  LANES  lane i product forced to 0 when low
- seg_end  in  LANES  bit i: row segment ends after lane i
- in_clr  in  1  discard accumulator carry for this beat's first segment
- out_valid  out  1  result beat present
- out_ready  in  1  result beat consumed when out_valid && out_ready
- out_mask  out  LANES  copy of seg_end for the beat; lane i sum is valid where set
- out_sum  out  LANES*ACCW  lane i = completed row sum ending at lane i; 0 where out_mask bit is clear

## Operation
- Product: p[i] = in_keep[i] ? signed(mat[i])*signed(vec[i]) : 0. The result is 2*DW bits, sign-extended to ACCW.
- All additions wrap modulo 2^ACCW. No saturation.
- Segment start: lane 0, or any lane i where seg_end[i-1] = 1.
- Segmented inclusive scan: s[i] = sum of p from the segment start up to lane i. Computed in log2(LANES) Hillis-Steele levels; a lane adds its neighbour only if no segment start lies between them.
- Effective accumulator: a = in_clr ? 0 : acc.
- Lane i is in the first segment when seg_end has no bit set below i.
- out_sum[i] = seg_end[i] ? s[i] + (first segment ? a : 0) : 0.
- acc_next = seg_end[LANES-1] ? 0 : s[LANES-1] + (seg_end == 0 ? a : 0).
- acc is read and written only in the final stage, so there is no hazard between back-to-back beats.
- Every accepted beat produces exactly one output beat, even when out_mask = 0.

## Timing
- Pipeline stages:
  - P: product register.
  - S1..S(log2 LANES): scan levels.
  - F: accumulator add and output register.
- Latency: L = log2(LANES)+2 cycles from acceptance to out_valid (L = 4 at default).
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: stall = out_valid && !out_ready. All stage registers and acc hold while stalled; in_ready = !stall (combinational).
- Stall invariant: out_sum, out_mask and out_valid are stable while stalled.
- Bubbles: a per-stage valid bit travels with the data. acc updates only when a valid beat leaves F into the output register.
- Reset (rst = 0 at a clk edge): all valid bits 0, acc 0, out_valid 0, out_mask 0, out_sum 0. In-flight beats are dropped; no carry survives.
- Boundaries:
  - seg_end all ones: every lane outputs its own product; lane 0 also receives a.
  - seg_end all zero: no output lanes; the whole beat plus a goes into acc.
  - in_clr with seg_end = 0: acc_next = beat sum.

## Structure
- Package sparse_mac_pkg holds:
  - default LANES/DW/ACCW localparams;
  - a clog2 function;
  - a sign-extend helper function.
- One sub-module, seg_scan_level. It is parametrised by distance d and is one registered scan level: it takes values and start flags, shifts by d, and applies the stall enable and valid bit. It is instantiated log2(LANES) times in a generate loop.

## Test plan
- Single beat: mat {1,2,3,4} (lane 0..3), vec all 1, keep 1111, seg_end 1000. Expect out_mask 1000 and lane 3 = 10, exactly 4 cycles after acceptance; other lanes 0.
- Carry across beats:
  - Beat A: products 5,5,5,5 with seg_end 0000.
  - Beat B: products 1,1,1,1 with seg_end 0010. Expect lane 1 = 22.
  - Beat C: products 1,0,0,0 with seg_end 0001. Expect lane 0 = 3.
- Signed extremes and keep: lane 0 = (-128)*(-128), lane 1 = (-128)*127, keep 0011, seg_end 0011. Expect lane 0 = 16384 and lane 1 = -16256.
- Backpressure: stream 6 back-to-back beats and hold out_ready low for 3 cycles once the pipe is full. Expect in_ready low throughout the stall, outputs stable, and all 6 results in order with none lost or duplicated.
- Clear: carry 20 pending, next beat has in_clr = 1, products 1,1,1,1, seg_end 1000. Expect lane 3 = 4.
- Reset mid-operation: 3 beats in flight with carry pending, rst low for 1 cycle. Expect out_valid 0 the next cycle, and that a following beat of 1,1,1,1 with seg_end 1000 yields 4.
